// File: rtl/adder_pipelined_if.sv
// Operand/result bus of the chunked pipelined adder: request side (a, b, c_in, sat) and result side (sum, c_out, ovf).
// Latency: none, wiring only.
// Backpressure: valid/ready on both sides; master drives requests and out_ready, slave drives in_ready and results.
interface adder_pipelined_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         c_in;
   logic         sat;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         c_out;
   logic         ovf;

   modport master (
      output in_valid, a, b, c_in, sat, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, sat, out_ready,
      output in_ready, out_valid, sum, c_out, ovf
   );
endinterface

// File: rtl/adder_pipelined.sv
// Unsigned N-bit adder split into STAGES carry chunks, one chunk added per pipeline stage, optional saturation.
// Latency: STAGES cycles from acceptance to out_valid; one transaction per cycle throughput.
// Backpressure: whole pipe advances only when the last slot is empty or drained; in_ready mirrors that advance.
module adder_pipelined #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   adder_pipelined_if.slave bus
);

   localparam int W    = N / STAGES;
   localparam int LAST = STAGES - 1;

   // Per-stage registers. part_q[k] holds result chunks 0..k; chunks above k are
   // still zero and get filled by the stages further down. a_q/b_q carry the full
   // operands so later stages can pick their chunk and the last stage sees the signs.
   logic         vld_q  [STAGES];
   logic [N-1:0] a_q    [STAGES];
   logic [N-1:0] b_q    [STAGES];
   logic [N-1:0] part_q [STAGES];
   logic         cy_q   [STAGES];
   logic         sat_q  [STAGES];

   // Next-state values for each stage register.
   logic         vld_d  [STAGES];
   logic [N-1:0] a_d    [STAGES];
   logic [N-1:0] b_d    [STAGES];
   logic [N-1:0] part_d [STAGES];
   logic         cy_d   [STAGES];
   logic         sat_d  [STAGES];

   // What each stage receives from upstream before adding its own chunk.
   logic [N-1:0] part_prev [STAGES];
   logic         cy_prev   [STAGES];
   logic [W:0]   chunk_sum [STAGES];

   logic adv;

   // A single advance for all stages keeps slots aligned, so ordering and
   // no-drop/no-duplicate fall out of the structure rather than per-stage logic.
   assign adv          = !vld_q[LAST] || bus.out_ready;
   assign bus.in_ready = adv;

   // Stage 0 is fed from the bus; every other stage is fed from its predecessor's registers.
   always_comb begin
      vld_d[0]     = bus.in_valid && adv;
      a_d[0]       = bus.a;
      b_d[0]       = bus.b;
      sat_d[0]     = bus.sat;
      part_prev[0] = '0;
      cy_prev[0]   = bus.c_in;
      for (int k = 1; k < STAGES; k++) begin
         vld_d[k]     = vld_q[k-1];
         a_d[k]       = a_q[k-1];
         b_d[k]       = b_q[k-1];
         sat_d[k]     = sat_q[k-1];
         part_prev[k] = part_q[k-1];
         cy_prev[k]   = cy_q[k-1];
      end
   end

   // Each stage adds only its own W-bit chunk plus the registered carry from the stage before,
   // so the longest carry chain is W bits and never spans a register boundary.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         chunk_sum[k] = {1'b0, a_d[k][k*W +: W]}
                      + {1'b0, b_d[k][k*W +: W]}
                      + {{W{1'b0}}, cy_prev[k]};
         part_d[k]              = part_prev[k];
         part_d[k][k*W +: W]    = chunk_sum[k][W-1:0];
         cy_d[k]                = chunk_sum[k][W];
      end
   end

   // Shift every stage together on advance, hold everything otherwise. Data is cleared on
   // reset as well as the valids so the derived outputs (sum, c_out, ovf) read as zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k]  <= 1'b0;
            a_q[k]    <= '0;
            b_q[k]    <= '0;
            part_q[k] <= '0;
            cy_q[k]   <= 1'b0;
            sat_q[k]  <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k]  <= vld_d[k];
            a_q[k]    <= a_d[k];
            b_q[k]    <= b_d[k];
            part_q[k] <= part_d[k];
            cy_q[k]   <= cy_d[k];
            sat_q[k]  <= sat_d[k];
         end
      end
   end

   // Results are decoded straight from the last stage registers, so they stay
   // frozen for as long as the stage is held by backpressure.
   assign bus.out_valid = vld_q[LAST];
   assign bus.c_out     = cy_q[LAST];
   assign bus.sum       = (sat_q[LAST] && cy_q[LAST]) ? {N{1'b1}} : part_q[LAST];
   // Signed overflow is judged on the raw sum, before any saturation is applied.
   assign bus.ovf       = (a_q[LAST][N-1] == b_q[LAST][N-1]) &&
                          (part_q[LAST][N-1] != a_q[LAST][N-1]);

endmodule

// File: tb/tb_adder_pipelined.sv
// Bench for adder_pipelined: three instances (8/2, 32/4, 8/1) checked every cycle against a queue model.
// Latency: directed vectors also pin acceptance-to-result latency and literal results.
// Backpressure: stalls, mid-stream reset and full-rate streaming are exercised on dedicated instances.
module tb_adder_pipelined;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   adder_pipelined_if #(.N(8))  b82  ();
   adder_pipelined_if #(.N(32)) b324 ();
   adder_pipelined_if #(.N(8))  b81  ();

   adder_pipelined #(.N(8),  .STAGES(2)) u82  (.clk(clk), .rst_n(rst_n), .bus(b82.slave));
   adder_pipelined #(.N(32), .STAGES(4)) u324 (.clk(clk), .rst_n(rst_n), .bus(b324.slave));
   adder_pipelined #(.N(8),  .STAGES(1)) u81  (.clk(clk), .rst_n(rst_n), .bus(b81.slave));

   typedef struct {
      logic [31:0] sum;
      logic        co;
      logic        ovf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   pops [3];
   int   checks = 0;
   int   errors = 0;

   // Reference: full-precision integer sum, then carry, overflow and saturation by definition.
   function automatic exp_t model(int n, logic [31:0] a, logic [31:0] b, logic ci, logic sat);
      longint unsigned mask, av, bv, raw;
      exp_t e;
      mask  = (64'd1 << n) - 64'd1;
      av    = {32'd0, a} & mask;
      bv    = {32'd0, b} & mask;
      raw   = av + bv + {63'd0, ci};
      e.co  = raw[n];
      e.sum = 32'(raw & mask);
      e.ovf = (av[n-1] == bv[n-1]) && (raw[n-1] != av[n-1]);
      if (sat && e.co) e.sum = 32'(mask);
      return e;
   endfunction

   task automatic check_eq(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
      end
   endtask

   // Per-cycle comparison of one instance against its expectation queue.
   task automatic chk(input int id, input int n, input logic rst, input logic iv, input logic ir,
                      input logic ov, input logic ordy, input logic [31:0] s, input logic co,
                      input logic of, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic sat);
      int   sz;
      exp_t e;
      case (id)
         0:       sz = q0.size();
         1:       sz = q1.size();
         default: sz = q2.size();
      endcase
      check_eq($sformatf("in_ready_rule[%0d]", id), 64'(ir), 64'(!ov || ordy));
      if (ov) begin
         if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_result[%0d]: out_valid=1 with nothing outstanding, sum=0x%0h", id, s);
         end else begin
            case (id)
               0:       e = q0[0];
               1:       e = q1[0];
               default: e = q2[0];
            endcase
            check_eq($sformatf("result[%0d] {sum,c_out,ovf}", id), {30'd0, s, co, of}, {30'd0, e.sum, e.co, e.ovf});
         end
      end
      if (!rst) begin
         case (id)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
         endcase
      end else begin
         if (ov && ordy && sz > 0) begin
            pops[id]++;
            case (id)
               0:       void'(q0.pop_front());
               1:       void'(q1.pop_front());
               default: void'(q2.pop_front());
            endcase
         end
         if (iv && ir) begin
            e = model(n, a, b, ci, sat);
            case (id)
               0:       q0.push_back(e);
               1:       q1.push_back(e);
               default: q2.push_back(e);
            endcase
         end
      end
   endtask

   // Compare process: all instances, every cycle, away from the active edge.
   always @(negedge clk) begin
      chk(0, 8, rst_n, b82.in_valid, b82.in_ready, b82.out_valid, b82.out_ready,
          32'(b82.sum), b82.c_out, b82.ovf, 32'(b82.a), 32'(b82.b), b82.c_in, b82.sat);
      chk(1, 32, rst_n, b324.in_valid, b324.in_ready, b324.out_valid, b324.out_ready,
          b324.sum, b324.c_out, b324.ovf, b324.a, b324.b, b324.c_in, b324.sat);
      chk(2, 8, rst_n, b81.in_valid, b81.in_ready, b81.out_valid, b81.out_ready,
          32'(b81.sum), b81.c_out, b81.ovf, 32'(b81.a), 32'(b81.b), b81.c_in, b81.sat);
   end

   // One transaction on the 8/2 instance with literal expectations; called #1 after a posedge, pipe empty.
   task automatic one8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic s, input logic [7:0] es, input logic eco, input logic eov);
      int k;
      b82.a = a; b82.b = b; b82.c_in = ci; b82.sat = s;
      b82.in_valid  = 1'b1;
      b82.out_ready = 1'b1;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
         if (k == 1) b82.in_valid = 1'b0;
      end while (!b82.out_valid && k < 10);
      check_eq({nm, "_latency"}, 64'(k), 64'(2));
      check_eq({nm, "_sum"},   64'(b82.sum),   64'(es));
      check_eq({nm, "_c_out"}, 64'(b82.c_out), 64'(eco));
      check_eq({nm, "_ovf"},   64'(b82.ovf),   64'(eov));
      @(posedge clk); #1;
   endtask

   // Offer one transaction on the 8/2 instance and hold it until accepted (bounded).
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s);
      int t;
      bit done;
      t = 0;
      done = 1'b0;
      b82.a = a; b82.b = b; b82.c_in = ci; b82.sat = s;
      b82.in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         done = b82.in_ready;
         @(posedge clk); #1;
         t++;
         if (!done && t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", t);
            done = 1'b1;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int k;
      int seen32, first32, last32, seen1, first1, last1;

      rst_n = 1'b0;
      b82.in_valid  = 1'b0; b82.a  = '0; b82.b  = '0; b82.c_in  = 1'b0; b82.sat  = 1'b0; b82.out_ready  = 1'b1;
      b324.in_valid = 1'b0; b324.a = '0; b324.b = '0; b324.c_in = 1'b0; b324.sat = 1'b0; b324.out_ready = 1'b1;
      b81.in_valid  = 1'b0; b81.a  = '0; b81.b  = '0; b81.c_in  = 1'b0; b81.sat  = 1'b0; b81.out_ready  = 1'b1;
      pops[0] = 0; pops[1] = 0; pops[2] = 0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_out_valid_8s2", 64'(b82.out_valid), 64'(0));
      check_eq("reset_sum_8s2",       64'(b82.sum),       64'(0));
      check_eq("reset_c_out_8s2",     64'(b82.c_out),     64'(0));
      check_eq("reset_ovf_8s2",       64'(b82.ovf),       64'(0));
      check_eq("reset_in_ready_8s2",  64'(b82.in_ready),  64'(1));
      check_eq("reset_out_valid_32s4", 64'(b324.out_valid), 64'(0));
      check_eq("reset_sum_32s4",       64'(b324.sum),       64'(0));
      check_eq("reset_out_valid_8s1",  64'(b81.out_valid),  64'(0));
      rst_n = 1'b1;

      // Directed vectors, first one offered on the very first cycle out of reset.
      one8("zero",         8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
      one8("wrap",         8'd127, 8'd128, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0);
      one8("saturate",     8'd127, 8'd128, 1'b1, 1'b1, 8'd255, 1'b1, 1'b0);
      one8("signed_ovf",   8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1);
      one8("minus1_plus1", 8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0);
      one8("neg_ovf_sat",  8'd128, 8'd128, 1'b0, 1'b1, 8'd255, 1'b1, 1'b1);
      one8("sat_no_carry", 8'd10,  8'd20,  1'b1, 1'b1, 8'd31,  1'b0, 1'b0);

      // Backpressure: four back-to-back offers while the output is stalled for three cycles.
      base = pops[0];
      b82.out_ready = 1'b0;
      fork
         begin
            send8(8'd1,   8'd2,   1'b0, 1'b0);
            send8(8'd100, 8'd100, 1'b0, 1'b0);
            send8(8'd200, 8'd100, 1'b0, 1'b1);
            send8(8'd5,   8'd250, 1'b1, 1'b0);
            b82.in_valid = 1'b0;
         end
         begin
            k = 0;
            do begin
               @(posedge clk); #1;
               k++;
            end while (!b82.out_valid && k < 20);
            check_eq("bp_first_latency", 64'(k), 64'(2));
            for (int i = 0; i < 3; i++) begin
               check_eq("bp_in_ready_low", 64'(b82.in_ready),  64'(0));
               check_eq("bp_out_valid",    64'(b82.out_valid), 64'(1));
               check_eq("bp_hold_sum",     64'(b82.sum),       64'(3));
               check_eq("bp_hold_c_out",   64'(b82.c_out),     64'(0));
               @(posedge clk); #1;
            end
            b82.out_ready = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      check_eq("bp_results_delivered", 64'(pops[0] - base), 64'(4));
      check_eq("bp_none_outstanding",  64'(q0.size()),      64'(0));

      // Reset with two transactions in flight: nothing from before may come out afterwards.
      send8(8'd10, 8'd20, 1'b0, 1'b0);
      send8(8'd30, 8'd40, 1'b0, 1'b0);
      b82.in_valid  = 1'b0;
      b82.out_ready = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_mid_out_valid", 64'(b82.out_valid), 64'(0));
      check_eq("rst_mid_sum",       64'(b82.sum),       64'(0));
      check_eq("rst_mid_in_ready",  64'(b82.in_ready),  64'(1));
      rst_n = 1'b1;
      b82.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("rst_no_stale", 64'(b82.out_valid), 64'(0));
      end
      one8("after_reset", 8'd50, 8'd60, 1'b1, 1'b0, 8'd111, 1'b0, 1'b0);

      // Full-rate streaming on the 32/4 and 8/1 instances.
      seen32 = 0; first32 = -1; last32 = -1;
      seen1  = 0; first1  = -1; last1  = -1;
      for (int i = 0; i < 110; i++) begin
         if (i < 100) begin
            b324.a = $urandom; b324.b = $urandom; b324.c_in = 1'($urandom); b324.sat = 1'($urandom);
            b324.in_valid = 1'b1;
            b81.a = 8'($urandom); b81.b = 8'($urandom); b81.c_in = 1'($urandom); b81.sat = 1'($urandom);
            b81.in_valid = 1'b1;
         end else begin
            b324.in_valid = 1'b0;
            b81.in_valid  = 1'b0;
         end
         @(posedge clk); #1;
         if (b324.out_valid) begin
            seen32++;
            if (first32 < 0) first32 = i + 1;
            last32 = i + 1;
         end
         if (b81.out_valid) begin
            seen1++;
            if (first1 < 0) first1 = i + 1;
            last1 = i + 1;
         end
      end
      check_eq("stream32_count", 64'(seen32),  64'(100));
      check_eq("stream32_first", 64'(first32), 64'(4));
      check_eq("stream32_last",  64'(last32),  64'(103));
      check_eq("stream8s1_count", 64'(seen1),  64'(100));
      check_eq("stream8s1_first", 64'(first1), 64'(1));
      check_eq("stream8s1_last",  64'(last1),  64'(100));

      repeat (5) @(posedge clk);
      #1;
      check_eq("final_outstanding_8s2",  64'(q0.size()), 64'(0));
      check_eq("final_outstanding_32s4", 64'(q1.size()), 64'(0));
      check_eq("final_outstanding_8s1",  64'(q2.size()), 64'(0));
      check_eq("stream32_delivered",     64'(pops[1]),   64'(100));
      check_eq("stream8s1_delivered",    64'(pops[2]),   64'(100));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
